// File: rtl/reg_wb_sequencer.sv
// Register-file write-port sequencer: merges ALU and buffered load writebacks,
// keeping same-register writes in program order via a per-register pending count.
module reg_wb_sequencer #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 3,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_wb_valid,
    input  logic [ADDR_W-1:0]          alu_wb_dest,
    input  logic [DATA_W-1:0]          alu_wb_data,
    output logic                       alu_wb_ready,
    input  logic                       mem_wb_valid,
    input  logic [ADDR_W-1:0]          mem_wb_dest,
    input  logic [DATA_W-1:0]          mem_wb_data,
    output logic                       mem_wb_ready,
    output logic                       reg_wr_en,
    output logic [ADDR_W-1:0]          reg_wr_dest,
    output logic [DATA_W-1:0]          reg_wr_data,
    output logic [(2**ADDR_W)-1:0]     pend_mask,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int unsigned NREG  = 2 ** ADDR_W;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = LVL_W;
    localparam int unsigned SC_W  = $clog2(STARVE_MAX + 1);

    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [ADDR_W-1:0] fifo_dest_q [DEPTH];
    logic [DATA_W-1:0] fifo_data_q [DEPTH];
    logic [CNT_W-1:0]  pend_q [NREG];
    logic [CNT_W-1:0]  pend_d [NREG];
    logic [SC_W-1:0]   starve_q, starve_d;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_dest_q;
    logic [DATA_W-1:0] wr_data_q;

    logic              push, pop, grant_alu, force_mem, fifo_empty;
    logic [NREG-1:0]   pend_vec;
    logic [ADDR_W-1:0] head_dest;
    logic [DATA_W-1:0] head_data;

    // Pending mask: a register is busy while any queued load still targets it
    always_comb begin
        pend_vec = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            pend_vec[r] = (pend_q[r] != '0);
        end
    end

    // Handshakes and grant selection; ALU wins unless blocked or starving the FIFO
    always_comb begin
        fifo_empty   = (level_q == '0);
        force_mem    = (starve_q == SC_W'(STARVE_MAX));
        alu_wb_ready = !pend_vec[alu_wb_dest] && !force_mem;
        mem_wb_ready = (level_q < LVL_W'(DEPTH));
        push         = mem_wb_valid && mem_wb_ready;
        grant_alu    = alu_wb_valid && alu_wb_ready;
        pop          = !grant_alu && !fifo_empty;
        head_dest    = fifo_dest_q[rd_ptr_q];
        head_data    = fifo_data_q[rd_ptr_q];
        level_d      = level_q + LVL_W'(push) - LVL_W'(pop);
    end

    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            pend_d[r] = pend_q[r];
            if (push && (mem_wb_dest == ADDR_W'(r))) begin
                pend_d[r] = pend_d[r] + CNT_W'(1);
            end
            if (pop && (head_dest == ADDR_W'(r))) begin
                pend_d[r] = pend_d[r] - CNT_W'(1);
            end
        end
    end

    // Count ALU grants that bypass waiting loads; cleared once a load is served
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (grant_alu) begin
            starve_d = starve_q + SC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            starve_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_dest_q <= '0;
            wr_data_q <= '0;
            for (int unsigned r = 0; r < NREG; r++) begin
                pend_q[r] <= '0;
            end
        end else begin
            level_q  <= level_d;
            starve_q <= starve_d;
            for (int unsigned r = 0; r < NREG; r++) begin
                pend_q[r] <= pend_d[r];
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (grant_alu) begin
                wr_en_q   <= 1'b1;
                wr_dest_q <= alu_wb_dest;
                wr_data_q <= alu_wb_data;
            end else if (pop) begin
                wr_en_q   <= 1'b1;
                wr_dest_q <= head_dest;
                wr_data_q <= head_data;
            end else begin
                wr_en_q   <= 1'b0;
            end
        end
    end

    // Load FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dest_q[wr_ptr_q] <= mem_wb_dest;
            fifo_data_q[wr_ptr_q] <= mem_wb_data;
        end
    end

    assign reg_wr_en   = wr_en_q;
    assign reg_wr_dest = wr_dest_q;
    assign reg_wr_data = wr_data_q;
    assign pend_mask   = pend_vec;
    assign fifo_level  = level_q;

endmodule

// File: tb/tb_reg_wb_sequencer.sv
// Randomized scoreboard bench for reg_wb_sequencer against a queue-based
// model of the arbitration, ordering and starvation rules.
module tb_reg_wb_sequencer;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 3;

    typedef struct packed {
        logic [2:0]  dest;
        logic [15:0] data;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        alu_wb_valid;
    logic [2:0]  alu_wb_dest;
    logic [15:0] alu_wb_data;
    logic        alu_wb_ready;
    logic        mem_wb_valid;
    logic [2:0]  mem_wb_dest;
    logic [15:0] mem_wb_data;
    logic        mem_wb_ready;
    logic        reg_wr_en;
    logic [2:0]  reg_wr_dest;
    logic [15:0] reg_wr_data;
    logic [7:0]  pend_mask;
    logic [2:0]  fifo_level;

    reg_wb_sequencer #(
        .DATA_W(16), .ADDR_W(3), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_wb_valid(alu_wb_valid), .alu_wb_dest(alu_wb_dest),
        .alu_wb_data(alu_wb_data), .alu_wb_ready(alu_wb_ready),
        .mem_wb_valid(mem_wb_valid), .mem_wb_dest(mem_wb_dest),
        .mem_wb_data(mem_wb_data), .mem_wb_ready(mem_wb_ready),
        .reg_wr_en(reg_wr_en), .reg_wr_dest(reg_wr_dest),
        .reg_wr_data(reg_wr_data), .pend_mask(pend_mask),
        .fifo_level(fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  n_vec = 0;
    int  n_err = 0;
    wr_t exp_q[$];
    wr_t load_q[$];
    int  starve = 0;
    bit  alu_pend = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of loads, pending = "some queued load targets r",
    // ALU first unless blocked or the loads have waited STARVE_MAX ALU grants.
    task automatic model_step();
        logic [7:0] m;
        bit force_m, e_alu_rdy, e_mem_rdy, g_alu, g_mem;
        wr_t w;
        m = '0;
        foreach (load_q[i]) m[load_q[i].dest] = 1'b1;
        force_m   = (starve == STARVE_MAX);
        e_alu_rdy = !m[alu_wb_dest] && !force_m;
        e_mem_rdy = (load_q.size() < DEPTH);
        chk("alu_wb_ready", 32'(alu_wb_ready), 32'(e_alu_rdy));
        chk("mem_wb_ready", 32'(mem_wb_ready), 32'(e_mem_rdy));
        chk("fifo_level", 32'(fifo_level), 32'(load_q.size()));
        chk("pend_mask", 32'(pend_mask), 32'(m));
        g_alu = alu_wb_valid && e_alu_rdy;
        g_mem = !g_alu && (load_q.size() != 0);
        if (g_alu) begin
            w.dest = alu_wb_dest;
            w.data = alu_wb_data;
            exp_q.push_back(w);
            alu_pend = 0;
        end else if (g_mem) begin
            exp_q.push_back(load_q[0]);
        end
        if (load_q.size() == 0 || g_mem) starve = 0;
        else if (g_alu) starve++;
        if (g_mem) void'(load_q.pop_front());
        if (mem_wb_valid && e_mem_rdy) begin
            w.dest = mem_wb_dest;
            w.data = mem_wb_data;
            load_q.push_back(w);
        end
    endtask

    task automatic run_phase(input int cycles, input int p_alu, input int p_mem, input int dest_max);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            if (!alu_pend && ($urandom_range(99) < p_alu)) begin
                alu_pend    = 1;
                alu_wb_dest = 3'($urandom_range(dest_max));
                alu_wb_data = 16'($urandom);
            end
            alu_wb_valid = alu_pend;
            mem_wb_valid = ($urandom_range(99) < p_mem);
            mem_wb_dest  = 3'($urandom_range(dest_max));
            mem_wb_data  = 16'($urandom);
            @(negedge clk);
            #1;
            model_step();
        end
    endtask

    // Monitor: each granted write must appear exactly one cycle later, in order
    logic [2:0]  last_dest = '0;
    logic [15:0] last_data = '0;
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                last_dest = '0;
                last_data = '0;
            end else if (reg_wr_en) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_write: got dest %0d data %0h, expected no write at %0t",
                             reg_wr_dest, reg_wr_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_dest", 32'(reg_wr_dest), 32'(e.dest));
                    chk("wr_data", 32'(reg_wr_data), 32'(e.data));
                    last_dest = e.dest;
                    last_data = e.data;
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL missing_write: got reg_wr_en 0, expected dest %0d data %0h at %0t",
                         e.dest, e.data, $time);
            end else begin
                chk("hold_dest", 32'(reg_wr_dest), 32'(last_dest));
                chk("hold_data", 32'(reg_wr_data), 32'(last_data));
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        alu_wb_valid = 1'b0;
        alu_wb_dest  = '0;
        alu_wb_data  = '0;
        mem_wb_valid = 1'b0;
        mem_wb_dest  = '0;
        mem_wb_data  = '0;
        #2;
        chk("rst_wr_en", 32'(reg_wr_en), 32'd0);
        chk("rst_fifo_level", 32'(fifo_level), 32'd0);
        chk("rst_pend_mask", 32'(pend_mask), 32'd0);
        chk("rst_mem_ready", 32'(mem_wb_ready), 32'd1);
        chk("rst_wr_dest", 32'(reg_wr_dest), 32'd0);
        chk("rst_wr_data", 32'(reg_wr_data), 32'd0);
        #10;
        rst_n = 1'b1;

        run_phase(30, 60, 0, 7);      // ALU only
        run_phase(20, 0, 70, 7);      // loads only, drained in order
        run_phase(40, 100, 100, 7);   // saturation: FIFO full, forced drains
        run_phase(60, 80, 60, 1);     // same-register conflicts
        run_phase(8, 100, 100, 3);    // build a backlog before reset

        // Asynchronous reset between edges discards the backlog
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_en", 32'(reg_wr_en), 32'd0);
        chk("midrst_fifo_level", 32'(fifo_level), 32'd0);
        chk("midrst_pend_mask", 32'(pend_mask), 32'd0);
        chk("midrst_mem_ready", 32'(mem_wb_ready), 32'd1);
        load_q.delete();
        starve       = 0;
        alu_pend     = 0;
        alu_wb_valid = 1'b0;
        mem_wb_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        run_phase(200, 50, 50, 7);    // mixed random traffic
        run_phase(12, 0, 0, 7);       // drain
        @(negedge clk);
        #2;
        chk("final_exp_empty", 32'(exp_q.size()), 32'd0);
        chk("final_fifo_level", 32'(fifo_level), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
